// File: rtl/generador_paquetes_if.sv
// Packet bus interface for generador_paquetes.
// Carries the upstream payload handshake (payload_in/payload_valid/payload_ready)
// and the downstream packet handshake (data_out/valid_out/ready_in).
// The master modport is the generator side; slave is the producer/consumer side.
interface generador_paquetes_if #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4
);
  localparam int PAYLOAD_W = BUS_SIZE - 2 * WORD_SIZE;

  logic [PAYLOAD_W-1:0] payload_in;
  logic                 payload_valid;
  logic                 payload_ready;
  logic [BUS_SIZE-1:0]  data_out;
  logic                 valid_out;
  logic                 ready_in;

  modport master (
    input  payload_in,
    input  payload_valid,
    input  ready_in,
    output payload_ready,
    output data_out,
    output valid_out
  );

  modport slave (
    output payload_in,
    output payload_valid,
    output ready_in,
    input  payload_ready,
    input  data_out,
    input  valid_out
  );
endinterface

// File: rtl/generador_paquetes.sv
// Transmit-side packet generator: builds {HEADER, payload, seq} packets and
// issues bursts of 1..2^WORD_SIZE packets over a valid/ready bus.
// Back-to-back packets are loaded on the same edge the previous one is
// accepted, giving one packet per cycle when both sides keep up.
// Optional build macro GEN_ERR_INJ_EN adds inj_hdr/inj_seq ports that corrupt
// the header word and/or create a sequence gap on a chosen packet.
module generador_paquetes #(
  parameter int                   BUS_SIZE  = 16,
  parameter int                   WORD_SIZE = 4,
  parameter logic [WORD_SIZE-1:0] HEADER    = WORD_SIZE'(4'hF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] burst_len,
  generador_paquetes_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           estado,
  output logic [4:0]           estado_proximo
`ifdef GEN_ERR_INJ_EN
  ,
  input  logic                 inj_hdr,
  input  logic                 inj_seq
`endif
);
  localparam int WORD_NUM  = BUS_SIZE / WORD_SIZE;
  localparam int PAYLOAD_W = (WORD_NUM - 2) * WORD_SIZE;
  localparam int REM_W     = WORD_SIZE + 1;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    WAIT_DATA = 5'b00010,
    SEND      = 5'b00100,
    STALL     = 5'b01000,
    DONE      = 5'b10000
  } state_t;

  state_t               state_q;
  state_t               state_nx;
  logic [BUS_SIZE-1:0]  data_q;
  logic [WORD_SIZE-1:0] seq_q;
  logic [WORD_SIZE-1:0] seq_nx;
  logic [REM_W-1:0]     rem_q;
  logic                 skip_q;
  logic                 load;
  logic                 start_burst;
  logic                 payload_ready_w;
  logic                 valid_w;
  logic                 accept;
  logic                 inj_hdr_w;
  logic                 inj_seq_w;

`ifdef GEN_ERR_INJ_EN
  assign inj_hdr_w = inj_hdr;
  assign inj_seq_w = inj_seq;
`else
  assign inj_hdr_w = 1'b0;
  assign inj_seq_w = 1'b0;
`endif

  // Header is inverted when corruption is requested for this packet.
  function automatic logic [BUS_SIZE-1:0] build_packet(
    input logic                 bad_hdr,
    input logic [PAYLOAD_W-1:0] payload,
    input logic [WORD_SIZE-1:0] seq
  );
    logic [WORD_SIZE-1:0] hdr;
    hdr = bad_hdr ? ~HEADER : HEADER;
    return {hdr, payload, seq};
  endfunction

  assign valid_w = (state_q == SEND) || (state_q == STALL);
  assign accept  = valid_w && bus.ready_in;

  // A packet that carried seq+1 moves the counter by two so the gap persists.
  assign seq_nx = accept ? (seq_q + (skip_q ? WORD_SIZE'(2) : WORD_SIZE'(1))) : seq_q;

  // Next-state and handshake decode.
  always_comb begin
    state_nx        = state_q;
    load            = 1'b0;
    start_burst     = 1'b0;
    payload_ready_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_burst = 1'b1;
          state_nx    = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.payload_valid) begin
          payload_ready_w = 1'b1;
          load            = 1'b1;
          state_nx        = SEND;
        end
      end
      SEND, STALL: begin
        if (!bus.ready_in) begin
          state_nx = STALL;
        end else if (rem_q == REM_W'(1)) begin
          state_nx = DONE;
        end else if (bus.payload_valid) begin
          payload_ready_w = 1'b1;
          load            = 1'b1;
          state_nx        = SEND;
        end else begin
          state_nx = WAIT_DATA;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Packet register; loaded packets use the post-acceptance sequence value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      skip_q <= 1'b0;
    end else if (load) begin
      data_q <= build_packet(inj_hdr_w, bus.payload_in,
                             seq_nx + (inj_seq_w ? WORD_SIZE'(1) : WORD_SIZE'(0)));
      skip_q <= inj_seq_w;
    end
  end

  // Sequence and remaining-packet counters; seq persists across bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q <= '0;
      rem_q <= '0;
    end else begin
      seq_q <= seq_nx;
      if (start_burst) begin
        rem_q <= (burst_len == '0) ? REM_W'(1 << WORD_SIZE) : {1'b0, burst_len};
      end else if (accept) begin
        rem_q <= rem_q - REM_W'(1);
      end
    end
  end

  assign bus.payload_ready = payload_ready_w;
  assign bus.data_out      = data_q;
  assign bus.valid_out     = valid_w;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign estado            = state_q;
  assign estado_proximo    = state_nx;
endmodule

// File: tb/tb_generador_paquetes.sv
// Testbench for generador_paquetes: directed scenarios plus randomized bursts,
// checked every cycle against a transaction-level model (payload queue,
// accepted-packet count, burst phase).
module tb_generador_paquetes;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic       busy;
  logic       done;
  logic [4:0] estado;
  logic [4:0] estado_proximo;
`ifdef GEN_ERR_INJ_EN
  logic       inj_hdr = 1'b0;
  logic       inj_seq = 1'b0;
`endif

  generador_paquetes_if #(.BUS_SIZE(16), .WORD_SIZE(4)) bus ();

  generador_paquetes dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_len      (burst_len),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .estado         (estado),
    .estado_proximo (estado_proximo)
`ifdef GEN_ERR_INJ_EN
    ,
    .inj_hdr        (inj_hdr),
    .inj_seq        (inj_seq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: a packet's seq is the number of packets accepted since reset, mod 16.
  int         phase = 0;      // 0 idle, 1 burst active, 2 done cycle
  int         mlen = 0;
  int         fetched = 0;
  int         acc_b = 0;
  int         total_acc = 0;
  bit         stalled = 1'b0;
  logic [7:0] pq[$];
  bit         m_ev, m_epr, m_acc;
  logic [4:0] m_es;
  logic [15:0] m_ed;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        phase = 0; total_acc = 0; stalled = 1'b0; pq.delete();
        chk("rst_valid",  32'(bus.valid_out), 32'd0);
        chk("rst_data",   32'(bus.data_out),  32'd0);
        chk("rst_estado", 32'(estado),        32'd1);
        chk("rst_done",   32'(done),          32'd0);
        chk("rst_busy",   32'(busy),          32'd0);
      end else begin
        m_ev  = (pq.size() > 0);
        m_epr = (phase == 1) && (fetched < mlen) && (!m_ev || bus.ready_in) && bus.payload_valid;
        if (phase == 0)      m_es = 5'b00001;
        else if (phase == 2) m_es = 5'b10000;
        else if (!m_ev)      m_es = 5'b00010;
        else if (stalled)    m_es = 5'b01000;
        else                 m_es = 5'b00100;
        chk("valid_out",     32'(bus.valid_out),     32'(m_ev));
        chk("payload_ready", 32'(bus.payload_ready), 32'(m_epr));
        chk("busy",          32'(busy),              32'(phase != 0));
        chk("done",          32'(done),              32'(phase == 2));
        chk("estado",        32'(estado),            32'(m_es));
        if (m_ev) begin
          m_ed = {4'hF, pq[0], 4'(total_acc % 16)};
          chk("data_out", 32'(bus.data_out), 32'(m_ed));
        end
        m_acc = m_ev && bus.ready_in;
        if (m_acc) begin
          void'(pq.pop_front());
          total_acc++; acc_b++; stalled = 1'b0;
        end else if (m_ev) begin
          stalled = 1'b1;
        end
        if (m_epr) begin
          pq.push_back(bus.payload_in);
          fetched++; stalled = 1'b0;
        end
        case (phase)
          0: if (start) begin
               phase = 1; mlen = (burst_len == 4'd0) ? 16 : int'(burst_len);
               fetched = 0; acc_b = 0;
             end
          1: if (m_acc && acc_b == mlen) phase = 2;
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int len);
    burst_len = 4'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_burst(input int pv_pct, input int rdy_pct);
    int n;
    n = 0;
    while (busy && n < 400) begin
      bus.payload_in    = 8'($urandom);
      bus.payload_valid = ($urandom_range(0, 99) < pv_pct);
      bus.ready_in      = ($urandom_range(0, 99) < rdy_pct);
      start             = ($urandom_range(0, 9) == 0);
      burst_len         = 4'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
    chk("burst_terminates", 32'(busy), 32'd0);
  endtask

  int         n;
  int         s0;

  initial begin
    bus.payload_in = 8'h00; bus.payload_valid = 1'b0; bus.ready_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Three packets at full rate from seq 0.
    bus.payload_in = 8'hA5; bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(3);
    tick(); chk("t1_pkt0", 32'(bus.data_out), 32'h0000FA50);
    tick(); chk("t1_pkt1", 32'(bus.data_out), 32'h0000FA51);
    tick(); chk("t1_pkt2", 32'(bus.data_out), 32'h0000FA52);
    tick(); chk("t1_done", 32'(done), 32'd1);
    tick(); chk("t1_idle", 32'(estado), 32'd1);
    chk("t1_done_once", 32'(done), 32'd0);

    // Downstream stall on the second packet.
    s0 = total_acc % 16;
    bus.payload_in = 8'h3C; bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(3);
    tick();
    tick();
    bus.ready_in = 1'b0;
    repeat (4) begin
      tick();
      chk("t2_stall_state", 32'(estado), 32'd8);
      chk("t2_stall_hold",  32'(bus.data_out), 32'({4'hF, 8'h3C, 4'(s0 + 1)}));
    end
    bus.ready_in = 1'b1;
    finish_burst(100, 100);

    // Upstream payload gap mid-burst.
    bus.payload_in = 8'h5A; bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(4);
    tick();
    bus.payload_valid = 1'b0;
    tick(); chk("t3_wait_state", 32'(estado), 32'd2);
    tick(); chk("t3_wait_valid", 32'(bus.valid_out), 32'd0);
    bus.payload_valid = 1'b1;
    finish_burst(100, 100);

    // Align seq to 14, then a 16-packet burst wraps and the next burst restarts at 14.
    n = (14 - (total_acc % 16) + 16) % 16;
    if (n != 0) begin
      bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
      start_burst(n);
      finish_burst(100, 100);
    end
    bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(0);
    tick(); chk("t4_first_seq", 32'(bus.data_out[3:0]), 32'd14);
    finish_burst(80, 80);
    bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(1);
    tick(); chk("t4_next_seq", 32'(bus.data_out[3:0]), 32'd14);
    finish_burst(100, 100);

    // Asynchronous reset while stalled.
    bus.payload_valid = 1'b1; bus.ready_in = 1'b0;
    start_burst(5);
    n = 0;
    while (estado != 5'd8 && n < 10) begin
      tick();
      n++;
    end
    chk("t5_reached_stall", 32'(estado), 32'd8);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_data",   32'(bus.data_out),  32'd0);
    chk("t5_async_valid",  32'(bus.valid_out), 32'd0);
    chk("t5_async_estado", 32'(estado),        32'd1);
    tick();
    tick();
    reset = 1'b1;
    bus.payload_in = 8'h77; bus.payload_valid = 1'b1; bus.ready_in = 1'b1;
    start_burst(2);
    tick(); chk("t5_seq_restart", 32'(bus.data_out), 32'h0000F770);
    finish_burst(100, 100);

    // Randomized bursts with random handshakes and stray start pulses.
    repeat (30) begin
      bus.payload_valid = $urandom_range(0, 1) == 1;
      bus.ready_in      = $urandom_range(0, 1) == 1;
      bus.payload_in    = 8'($urandom);
      start_burst(int'($urandom_range(0, 15)));
      finish_burst(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
